// File: rtl/niossoc_pio_pkg.sv
// Shared definitions for the NIOS SoC parallel-I/O register blocks.
package niossoc_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE    = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage

// File: rtl/niossoc_sync_bus.sv
// WIDTH-bit multi-flop synchronizer with asynchronous active-high reset.
module niossoc_sync_bus #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/niossoc_pio_in.sv
// Avalon-MM input PIO: synchronized data, per-bit edge capture and masked irq.
module niossoc_pio_in
  import niossoc_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam edge_type_e EDGE_SEL = edge_type_e'(EDGE_TYPE[1:0]);
  localparam logic [2:0] ARM_LOAD = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] cap_q,  cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [2:0]       arm_q,  arm_d;
  logic [WIDTH-1:0] edge_det;
  logic             armed;
  logic             wr;

  niossoc_sync_bus #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (in_port),
    .q_o   (sync_q)
  );

  assign wr    = chipselect && !write_n;
  assign armed = (arm_q == '0);

  always_comb begin
    edge_det = '0;
    case (EDGE_SEL)
      EDGE_RISE: edge_det = sync_q & ~prev_q;
      EDGE_FALL: edge_det = ~sync_q & prev_q;
      default:   edge_det = sync_q ^ prev_q;
    endcase
  end

  always_comb begin
    arm_d  = armed ? arm_q : arm_q - 3'd1;
    mask_d = mask_q;
    cap_d  = cap_q;
    if (wr && address == PIO_ADDR_IRQMASK) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr && address == PIO_ADDR_EDGE) begin
      cap_d = cap_q & ~writedata[WIDTH-1:0];
    end
    // Applied after the clear so a coincident edge keeps its bit set.
    if (armed) begin
      cap_d = cap_d | edge_det;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (address)
      PIO_ADDR_DATA:    rdata_d[WIDTH-1:0] = sync_q;
      PIO_ADDR_DIR:     rdata_d = '0;
      PIO_ADDR_IRQMASK: rdata_d[WIDTH-1:0] = mask_q;
      PIO_ADDR_EDGE:    rdata_d[WIDTH-1:0] = cap_q;
      default:          rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= '0;
      cap_q   <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      arm_q   <= ARM_LOAD;
    end else begin
      prev_q  <= sync_q;
      cap_q   <= cap_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      arm_q   <= arm_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_niossoc_pio_in.sv
// Scoreboard bench: a rising-edge and an any-edge PIO share one Avalon bus.
module tb_niossoc_pio_in;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_port0, in_port2;
  logic [31:0] readdata0, readdata2;
  logic        irq0, irq2;

  niossoc_pio_in #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port0),
    .readdata(readdata0), .irq(irq0)
  );

  niossoc_pio_in #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port2),
    .readdata(readdata2), .irq(irq2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] e0;
    logic [31:0] e2;
    string       name;
  } rd_exp_t;

  typedef struct {
    logic        i0;
    logic        i2;
    bit          chk_rd;
    logic [31:0] r0;
    logic [31:0] r2;
    string       name;
  } st_exp_t;

  rd_exp_t rdq[$];
  st_exp_t stq[$];
  int      checks = 0;
  int      errors = 0;
  logic    rd_req = 1'b0;
  logic    rd_tag = 1'b0;
  logic    st_req = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Read data is valid one cycle after the read is presented.
  always @(posedge clk) rd_tag <= rd_req;

  always @(negedge clk) begin
    if (rd_tag) begin
      if (rdq.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_underflow actual=empty required=entry");
      end else begin
        rd_exp_t e;
        e = rdq.pop_front();
        cmp({e.name, "_dut0"}, readdata0, e.e0);
        cmp({e.name, "_dut2"}, readdata2, e.e2);
      end
    end
    if (st_req) begin
      if (stq.size() == 0) begin
        checks++; errors++;
        $display("FAIL st_underflow actual=empty required=entry");
      end else begin
        st_exp_t s;
        s = stq.pop_front();
        cmp({s.name, "_irq0"}, {31'd0, irq0}, {31'd0, s.i0});
        cmp({s.name, "_irq2"}, {31'd0, irq2}, {31'd0, s.i2});
        if (s.chk_rd) begin
          cmp({s.name, "_rd0"}, readdata0, s.r0);
          cmp({s.name, "_rd2"}, readdata2, s.r2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rd_req     = 1'b0;
    st_req     = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic [31:0] e0,
                        input logic [31:0] e2, input string nm);
    rd_exp_t e;
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    e.e0 = e0; e.e2 = e2; e.name = nm;
    rdq.push_back(e);
    rd_req = 1'b1;
  endtask

  task automatic exp_irq(input logic i0, input logic i2, input string nm);
    st_exp_t s;
    s.i0 = i0; s.i2 = i2; s.chk_rd = 1'b0; s.r0 = '0; s.r2 = '0; s.name = nm;
    stq.push_back(s);
    st_req = 1'b1;
  endtask

  task automatic exp_state(input logic i0, input logic i2, input logic [31:0] r0,
                           input logic [31:0] r2, input string nm);
    st_exp_t s;
    s.i0 = i0; s.i2 = i2; s.chk_rd = 1'b1; s.r0 = r0; s.r2 = r2; s.name = nm;
    stq.push_back(s);
    st_req = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port0 = 32'h0000_00A5; in_port2 = '0;

    // Reset values, then reads right after release with in_port0 held high.
    step(); step(); step();
    exp_state(1'b0, 1'b0, 32'h0, 32'h0, "in_reset");
    step(); reset = 1'b0; bus_rd(2'd1, 32'h0, 32'h0, "rd_reserved");
    step(); bus_rd(2'd2, 32'h0, 32'h0, "rd_mask_rst");
    step(); bus_rd(2'd3, 32'h0, 32'h0, "rd_edge_rst");
    step(); bus_rd(2'd0, 32'h0000_00A5, 32'h0, "rd_data_armed");
    step();
    step(); bus_rd(2'd3, 32'h0, 32'h0, "rd_no_false_cap"); exp_irq(1'b0, 1'b0, "irq_no_false_cap");

    // Falls are ignored on the rising-edge instance; then a rise on bits 0 and 8.
    step(); bus_wr(2'd2, 32'h0000_0001); in_port0 = 32'h0;
    step(); step(); step();
    step(); bus_rd(2'd3, 32'h0, 32'h0, "rd_fall_ignored");
    step(); in_port0 = 32'h0000_0101; exp_irq(1'b0, 1'b0, "irq_t0");
    step(); exp_irq(1'b0, 1'b0, "irq_t1");
    step(); exp_irq(1'b0, 1'b0, "irq_t2");
    step(); exp_irq(1'b1, 1'b0, "irq_t3"); bus_rd(2'd3, 32'h0000_0101, 32'h0, "rd_cap_101");
    step(); bus_wr(2'd3, 32'h0000_0001); exp_irq(1'b1, 1'b0, "irq_before_clr");
    step(); exp_irq(1'b0, 1'b0, "irq_after_clr"); bus_rd(2'd3, 32'h0000_0100, 32'h0, "rd_cap_100");

    // Bit-4 rise lands on the same edge as its clear: the set must survive.
    step(); in_port0 = 32'h0000_0111;
    step();
    step(); bus_wr(2'd3, 32'h0000_0010);
    step(); bus_rd(2'd3, 32'h0000_0110, 32'h0, "rd_set_wins"); exp_irq(1'b0, 1'b0, "irq_bit4_masked");
    step(); bus_wr(2'd2, 32'h0000_0010);
    step(); exp_irq(1'b1, 1'b0, "irq_bit4_unmasked");

    // Three-cycle pulse on bit 31: any-edge instance captures rise and fall.
    step(); bus_wr(2'd2, 32'h8000_0000);
    step(); exp_irq(1'b0, 1'b0, "irq_mask31"); in_port2 = 32'h8000_0000; in_port0 = 32'h0000_0110;
    step();
    step();
    step(); in_port2 = 32'h0; exp_irq(1'b0, 1'b1, "irq_rise_any");
    step(); bus_wr(2'd3, 32'h8000_0000);
    step(); exp_irq(1'b0, 1'b0, "irq_clr31");
    step(); exp_irq(1'b0, 1'b1, "irq_fall_any");
    step(); bus_rd(2'd3, 32'h0000_0110, 32'h8000_0000, "rd_cap_any");
    step(); bus_wr(2'd2, 32'h0);
    step(); exp_irq(1'b0, 1'b0, "irq_mask_off"); bus_rd(2'd2, 32'h0, 32'h0, "rd_mask0");
    step(); bus_wr(2'd3, 32'h8000_0000);
    step(); bus_rd(2'd3, 32'h0000_0110, 32'h0, "rd_clr31");

    // Asynchronous reset mid-cycle while irq is high.
    step(); bus_wr(2'd2, 32'hFFFF_FFFF);
    step(); bus_rd(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "rd_mask_ff"); exp_irq(1'b1, 1'b0, "irq_all_masked");
    step();
    step(); #2; reset = 1'b1; exp_state(1'b0, 1'b0, 32'h0, 32'h0, "async_rst");
    step();
    step(); reset = 1'b0; bus_rd(2'd2, 32'h0, 32'h0, "rd_mask_after_rst");
    step(); bus_rd(2'd3, 32'h0, 32'h0, "rd_cap_after_rst");
    step(); bus_rd(2'd3, 32'h0, 32'h0, "rd_cap_rearm");
    step(); bus_rd(2'd3, 32'h0, 32'h0, "rd_no_false_cap2"); exp_irq(1'b0, 1'b0, "irq_rearmed");
    step(); bus_rd(2'd0, 32'h0000_0110, 32'h0, "rd_data_after_rst");
    step(); step(); step();

    checks++;
    if (rdq.size() != 0 || stq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", rdq.size() + stq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
